// File: rtl/freq_frame_buffer_pkg.sv
// freq_buf_pkg: shared constants and the writer state encoding for the
// frequency-domain ping-pong frame buffer.
package freq_buf_pkg;

    // Bins captured per FFT frame (positive half of a 1024-point frame)
    localparam int NUM_BINS       = 512;

    // Default widths for the buffer top level
    localparam int BIN_ADDR_W_DEF = 9;
    localparam int DATA_W_DEF     = 8;

    // Writer states, one-hot
    typedef enum logic [2:0] {
        stWaitSof = 3'b001,
        stFill    = 3'b010,
        stFull    = 3'b100
    } wrState_t;

    // True when a sample index lies in the captured (positive) half
    function automatic logic isLowHalf(input logic [9:0] addr);
        return (addr < 10'(NUM_BINS));
    endfunction

endpackage

// File: rtl/freq_bank_ram.sv
// freq_bank_ram: simple dual-port RAM holding both spectrum banks.
// Address is {bank, bin}. Writes are synchronous; the read port has a
// registered output that doubles as the display data register, so it is
// cleared by the asynchronous reset.
module freq_bank_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              ckFreq,
    input  logic              aresetn,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port: sample lands on the edge it is accepted
    always_ff @(posedge ckFreq) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read port: one-cycle latency, output register resets to zero
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/freq_frame_buffer.sv
// freq_frame_buffer: captures bins 0..511 of each FFT magnitude frame into
// a ping-pong buffer; the display reads the stable bank while the other
// fills. Banks swap only on a display vsync after a complete frame.
// Optional peak statistics are compiled in with `define FREQ_STATS_EN.
module freq_frame_buffer
    import freq_buf_pkg::*;
#(
    parameter int BIN_ADDR_W = BIN_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  ckFreq,
    input  logic                  aresetn,
    input  logic                  flgFreqSampleValid,
    input  logic [9:0]            addrFreq,
    input  logic [DATA_W-1:0]     byteFreqSample,
    input  logic                  flgDisplayVsync,
    input  logic [BIN_ADDR_W-1:0] addrDisplay,
    output logic [DATA_W-1:0]     byteDisplay,
    output logic                  flgFrameReady,
    output logic [7:0]            cntDropped,
    output logic [BIN_ADDR_W-1:0] peakBin,
    output logic [DATA_W-1:0]     peakVal
);

    localparam logic [BIN_ADDR_W-1:0] LAST_BIN = '1;

    wrState_t              state;
    logic [BIN_ADDR_W-1:0] cntBin;
    logic                  bankWr;

    // Decoded per-cycle events
    logic                  sofHit;     // valid sample at bin 0
    logic                  lowHalf;    // valid sample in captured half
    logic                  inSeq;      // valid sample at the expected bin
    logic                  swapNow;    // held frame released by vsync
    logic                  sofAccept;  // bin 0 starts a new capture
    logic                  seqWrite;   // in-order bin during fill
    logic                  abortFill;  // out-of-order bin that is not a SOF
    logic                  dropSof;    // SOF arriving while frame is held

    logic                  wrEn;
    logic [BIN_ADDR_W-1:0] wrBin;
    logic                  wrBank;

    // Classify the incoming sample against the writer state
    always_comb begin
        sofHit    = flgFreqSampleValid && (addrFreq == 10'd0);
        lowHalf   = flgFreqSampleValid && isLowHalf(addrFreq);
        inSeq     = lowHalf && (addrFreq[BIN_ADDR_W-1:0] == cntBin);
        swapNow   = (state == stFull) && flgDisplayVsync;
        seqWrite  = (state == stFill) && inSeq;
        sofAccept = sofHit && ((state == stWaitSof) ||
                               ((state == stFill) && !inSeq) ||
                               swapNow);
        abortFill = (state == stFill) && lowHalf && !inSeq && !sofHit;
        dropSof   = (state == stFull) && sofHit && !flgDisplayVsync;

        wrEn      = sofAccept || seqWrite;
        wrBin     = sofAccept ? '0 : cntBin;
        // On a swap the new fill bank is the one being released by the display
        wrBank    = swapNow ? ~bankWr : bankWr;
    end

    // Writer FSM: bin sequencing, bank swap, frame-ready pulse, drop counter
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            state         <= stWaitSof;
            cntBin        <= '0;
            bankWr        <= 1'b0;
            flgFrameReady <= 1'b0;
            cntDropped    <= 8'd0;
        end else begin
            flgFrameReady <= swapNow;

            if (swapNow) begin
                bankWr <= ~bankWr;
            end

            if (dropSof && (cntDropped != 8'hFF)) begin
                cntDropped <= cntDropped + 8'd1;
            end

            if (sofAccept) begin
                state  <= stFill;
                cntBin <= BIN_ADDR_W'(1);
            end else begin
                unique case (state)
                    stWaitSof: begin
                        state <= stWaitSof;
                    end
                    stFill: begin
                        if (seqWrite) begin
                            cntBin <= cntBin + BIN_ADDR_W'(1);
                            if (cntBin == LAST_BIN) begin
                                state <= stFull;
                            end
                        end else if (abortFill) begin
                            state  <= stWaitSof;
                            cntBin <= '0;
                        end
                    end
                    stFull: begin
                        if (swapNow) begin
                            state  <= stWaitSof;
                            cntBin <= '0;
                        end
                    end
                    default: begin
                        state  <= stWaitSof;
                        cntBin <= '0;
                    end
                endcase
            end
        end
    end

    freq_bank_ram #(
        .ADDR_W (BIN_ADDR_W + 1),
        .DATA_W (DATA_W)
    ) uBankRam (
        .ckFreq  (ckFreq),
        .aresetn (aresetn),
        .wrEn    (wrEn),
        .wrAddr  ({wrBank, wrBin}),
        .wrData  (byteFreqSample),
        .rdAddr  ({~bankWr, addrDisplay}),
        .rdData  (byteDisplay)
    );

`ifdef FREQ_STATS_EN
    logic [BIN_ADDR_W-1:0] runBin;
    logic [DATA_W-1:0]     runVal;

    // Running max over non-DC bins of the frame being filled; latched on swap
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            runBin  <= '0;
            runVal  <= '0;
            peakBin <= '0;
            peakVal <= '0;
        end else begin
            if (swapNow) begin
                peakBin <= runBin;
                peakVal <= runVal;
            end
            if (sofAccept) begin
                runBin <= '0;
                runVal <= '0;
            end else if (seqWrite && (byteFreqSample > runVal)) begin
                runBin <= cntBin;
                runVal <= byteFreqSample;
            end
        end
    end
`else
    assign peakBin = '0;
    assign peakVal = '0;
`endif

endmodule

// File: tb/tb_freq_frame_buffer.sv
// tb_freq_frame_buffer: directed scenarios plus randomized streaming,
// checked every cycle against a frame-level model of the buffer.
module tb_freq_frame_buffer;

    logic       ckFreq = 1'b0;
    logic       aresetn = 1'b0;
    logic       flgFreqSampleValid = 1'b0;
    logic [9:0] addrFreq = '0;
    logic [7:0] byteFreqSample = '0;
    logic       flgDisplayVsync = 1'b0;
    logic [8:0] addrDisplay = '0;
    logic [7:0] byteDisplay;
    logic       flgFrameReady;
    logic [7:0] cntDropped;
    logic [8:0] peakBin;
    logic [7:0] peakVal;

    freq_frame_buffer dut (
        .ckFreq             (ckFreq),
        .aresetn            (aresetn),
        .flgFreqSampleValid (flgFreqSampleValid),
        .addrFreq           (addrFreq),
        .byteFreqSample     (byteFreqSample),
        .flgDisplayVsync    (flgDisplayVsync),
        .addrDisplay        (addrDisplay),
        .byteDisplay        (byteDisplay),
        .flgFrameReady      (flgFrameReady),
        .cntDropped         (cntDropped),
        .peakBin            (peakBin),
        .peakVal            (peakVal)
    );

    always #5 ckFreq = ~ckFreq;

    int nVec = 0;
    int nMis = 0;
    int nChecks = 0;
    int rdyCount = 0;
    bit chkOn = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // mPhase: 0 waiting for bin 0, 1 collecting bins, 2 holding a complete frame
    int         mPhase = 0;
    int         mNext = 0;
    logic [7:0] fillBuf [512];
    logic [7:0] dispBuf [512];
    bit         dispValid = 0;
    logic [7:0] expByte = '0;
    bit         expByteValid = 1;
    bit         expReady = 0;
    int         expDropped = 0;
    int         expPeakBin = 0;
    int         expPeakVal = 0;
    bit         mSof, mLow;

    // Strongest non-DC bin of the displayed frame, lowest bin on ties
    task automatic scanPeak();
        expPeakBin = 0;
        expPeakVal = 0;
        for (int i = 1; i < 512; i++) begin
            if (int'(dispBuf[i]) > expPeakVal) begin
                expPeakVal = int'(dispBuf[i]);
                expPeakBin = i;
            end
        end
    endtask

    task automatic startFrame(input logic [7:0] d);
        fillBuf[0] = d;
        mNext = 1;
        mPhase = 1;
    endtask

    always @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            mPhase = 0; mNext = 0; dispValid = 0;
            expByte = '0; expByteValid = 1; expReady = 0;
            expDropped = 0; expPeakBin = 0; expPeakVal = 0;
        end else begin
            expByteValid = dispValid;
            expByte = dispBuf[addrDisplay];
            expReady = 0;
            mSof = flgFreqSampleValid && (addrFreq == 10'd0);
            mLow = flgFreqSampleValid && (addrFreq < 10'd512);
            if (mPhase == 1 && mLow && int'(addrFreq) == mNext) begin
                fillBuf[addrFreq[8:0]] = byteFreqSample;
                mNext++;
                if (mNext == 512) mPhase = 2;
            end else if (mPhase == 2 && flgDisplayVsync) begin
                dispBuf = fillBuf;
                dispValid = 1;
                expReady = 1;
                scanPeak();
                mPhase = 0;
                if (mSof) startFrame(byteFreqSample);
            end else if (mPhase == 2) begin
                if (mSof && expDropped < 255) expDropped++;
            end else if (mSof) begin
                startFrame(byteFreqSample);
            end else if (mPhase == 1 && mLow) begin
                mPhase = 0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge ckFreq) begin
        if (chkOn) begin
            if (expByteValid) check("byteDisplay", 32'(byteDisplay), 32'(expByte));
            check("flgFrameReady", 32'(flgFrameReady), 32'(expReady));
            check("cntDropped", 32'(cntDropped), expDropped);
`ifdef FREQ_STATS_EN
            check("peakBin", 32'(peakBin), expPeakBin);
            check("peakVal", 32'(peakVal), expPeakVal);
`else
            check("peakBin", 32'(peakBin), 32'd0);
            check("peakVal", 32'(peakVal), 32'd0);
`endif
            if (flgFrameReady) rdyCount++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [9:0] a, input logic [7:0] d,
                         input logic vs, input logic [8:0] ra);
        flgFreqSampleValid = v;
        addrFreq = a;
        byteFreqSample = d;
        flgDisplayVsync = vs;
        addrDisplay = ra;
        nVec++;
        @(negedge ckFreq);
    endtask

    function automatic logic [7:0] binVal(input int b, input int mode);
        logic [31:0] t;
        case (mode)
            0: t = 32'(b);
            1: t = 32'(b * 3);
            3: t = (b == 0) ? 32'd255 : ((b == 40 || b == 77) ? 32'd200 :
                   ((b >= 512) ? $urandom : 32'd10));
            default: t = $urandom;
        endcase
        return t[7:0];
    endfunction

    task automatic sendBins(input int first, input int last, input int mode);
        logic [31:0] b32;
        for (int b = first; b <= last; b++) begin
            b32 = 32'(b);
            drive(1'b1, b32[9:0], binVal(b, mode), 1'b0, 9'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 10'd0, 8'd0, 1'b0, 9'($urandom));
    endtask

    task automatic vsync();
        drive(1'b0, 10'd0, 8'd0, 1'b1, 9'($urandom));
    endtask

    task automatic readAt(input logic [8:0] ra, input logic [7:0] want, input string nm);
        drive(1'b0, 10'd0, 8'd0, 1'b0, ra);
        check(nm, 32'(byteDisplay), 32'(want));
    endtask

    task automatic randomPhase(input int cycles);
        int ctr;
        logic v, vs;
        logic [31:0] c32;
        ctr = 0;
        for (int i = 0; i < cycles; i++) begin
            v = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 399) == 0) ctr = $urandom_range(0, 1023);
            c32 = 32'(ctr);
            if (v) ctr = (ctr + 1) % 1024;
            vs = ($urandom_range(0, 149) == 0);
            drive(v, c32[9:0], 8'($urandom), vs, 9'($urandom));
        end
    endtask

    int rc;

    initial begin
        // Reset state
        repeat (2) @(negedge ckFreq);
        check("rst_byteDisplay", 32'(byteDisplay), 32'd0);
        check("rst_flgFrameReady", 32'(flgFrameReady), 32'd0);
        check("rst_cntDropped", 32'(cntDropped), 32'd0);
        check("rst_peakBin", 32'(peakBin), 32'd0);
        check("rst_peakVal", 32'(peakVal), 32'd0);
        aresetn = 1'b1;
        chkOn = 1;
        idle(3);

        // Full frame with value = bin[7:0], mirror half included, then vsync
        rc = rdyCount;
        sendBins(0, 1023, 0);
        idle(2);
        vsync();
        check("t1_ready", 32'(flgFrameReady), 32'd1);
        idle(2);
        check("t1_readyCount", 32'(rdyCount - rc), 32'd1);
        readAt(9'd5, 8'd5, "t1_bin5");
        readAt(9'd300, 8'd44, "t1_bin300");

        // Overrun: complete frame, 3 SOFs without vsync, then vsync
        sendBins(0, 1023, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10'd0, 8'($urandom), 1'b0, 9'($urandom));
            sendBins(1, 20, 2);
        end
        idle(2);
        check("t2_dropped", 32'(cntDropped), 32'd3);
        vsync();
        idle(1);
        check("t2_dropped_after", 32'(cntDropped), 32'd3);
        readAt(9'd7, 8'd21, "t2_bin7");
        readAt(9'd200, 8'd88, "t2_bin200");

        // Vsync and SOF in the same cycle while holding a frame
        sendBins(0, 511, 2);
        drive(1'b1, 10'd0, 8'hAB, 1'b1, 9'($urandom));
        check("t3_ready", 32'(flgFrameReady), 32'd1);
        check("t3_dropped", 32'(cntDropped), 32'd3);
        sendBins(1, 511, 2);
        vsync();
        check("t3_ready2", 32'(flgFrameReady), 32'd1);
        readAt(9'd0, 8'hAB, "t3_bin0");

        // Out-of-order jump aborts the frame; next clean frame captures
        rc = rdyCount;
        sendBins(0, 100, 2);
        sendBins(200, 511, 2);
        vsync();
        idle(2);
        check("t4_noswap", 32'(rdyCount - rc), 32'd0);
        sendBins(0, 1023, 2);
        vsync();
        idle(1);
        check("t4_swap", 32'(rdyCount - rc), 32'd1);

        // Asynchronous reset mid-fill
        sendBins(0, 250, 2);
        #2 aresetn = 1'b0;
        #1;
        check("t5_byteDisplay", 32'(byteDisplay), 32'd0);
        check("t5_flgFrameReady", 32'(flgFrameReady), 32'd0);
        check("t5_cntDropped", 32'(cntDropped), 32'd0);
        check("t5_peakBin", 32'(peakBin), 32'd0);
        check("t5_peakVal", 32'(peakVal), 32'd0);
        @(negedge ckFreq);
        @(negedge ckFreq);
        aresetn = 1'b1;
        idle(2);
        rc = rdyCount;
        sendBins(251, 511, 2);
        vsync();
        idle(1);
        check("t5_waitsof", 32'(rdyCount - rc), 32'd0);
        sendBins(0, 1023, 2);
        vsync();
        idle(1);
        check("t5_swap", 32'(rdyCount - rc), 32'd1);

        // Peak statistics pattern
        sendBins(0, 1023, 3);
        vsync();
        idle(1);
`ifdef FREQ_STATS_EN
        check("t6_peakBin", 32'(peakBin), 32'd40);
        check("t6_peakVal", 32'(peakVal), 32'd200);
`else
        check("t6_peakBin", 32'(peakBin), 32'd0);
        check("t6_peakVal", 32'(peakVal), 32'd0);
`endif
        readAt(9'd77, 8'd200, "t6_bin77");

        // Randomized streaming with glitches and free-running vsync
        randomPhase(5000);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/freq_frame_buffer.md
# freq_frame_buffer

Captures the positive half of each FFT output frame (bins 0..511 of the 1024-point magnitude stream carried by flgFreqSampleValid/addrFreq/byteFreqSample) into a ping-pong spectrum buffer on the ckFreq domain. The display side reads one stable bank while the other fills. Banks swap only at a display frame boundary, so the display never tears. The block sits directly downstream of the FFT power/gain stage and upstream of the spectrum display renderer.

## Interface
Parameters:
- BIN_ADDR_W, 9, width of the captured bin index; 2**BIN_ADDR_W bins are captured per frame
- DATA_W, 8, width of a frequency sample

Ports:
- ckFreq  in  1  sole clock; all logic is on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- flgFreqSampleValid  in  1  qualifies addrFreq/byteFreqSample in the same cycle
- addrFreq  in  10  bin index of the incoming sample (0..1023)
- byteFreqSample  in  DATA_W  gained power value of that bin
- flgDisplayVsync  in  1  single-cycle pulse at the display frame boundary
- addrDisplay  in  BIN_ADDR_W  display read address
- byteDisplay  out  DATA_W  display read data, registered
- flgFrameReady  out  1  one-cycle pulse on every bank swap
- cntDropped  out  8  saturating count of completed FFT frames discarded while the buffer was full
- peakBin  out  BIN_ADDR_W  strongest non-DC bin of the displayed frame (FREQ_STATS_EN only)
- peakVal  out  DATA_W  value at peakBin (FREQ_STATS_EN only)

## Operation
- Storage is two banks of 512×8. bankWr selects the fill bank; the display reads bank !bankWr.
- Samples with addrFreq[9] == 1 (mirror half) are ignored in every state.
- The writer FSM has three states, stWaitSof, stFill and stFull. Reset state is stWaitSof.
- stWaitSof:
  - On valid && addrFreq == 0: write bin 0, set cntBin to 1, go to stFill.
  - All other samples are ignored.
- stFill:
  - On valid && addrFreq[8:0] == cntBin: write the sample and increment cntBin.
  - When bin 511 is written, go to stFull.
  - On valid && addrFreq[8:0] != cntBin (resync or glitch), with addrFreq < 512:
    - Abort to stWaitSof. The partial bank is never shown.
    - If that same sample has addrFreq == 0, treat it as a new SOF: write bin 0 and stay in stFill with cntBin = 1.
- stFull:
  - On flgDisplayVsync: toggle bankWr, pulse flgFrameReady, go to stWaitSof.
  - A SOF (valid && addrFreq == 0) without a vsync in the same cycle increments cntDropped. cntDropped saturates at 255. The held frame is kept.
  - A vsync and a SOF in the same cycle: the swap wins. Bin 0 is written into the new fill bank and the FSM goes to stFill. cntDropped is not incremented.
- flgDisplayVsync is ignored in stWaitSof and stFill.
- Reset values:
  - bankWr = 0, state = stWaitSof, cntBin = 0.
  - byteDisplay = 0, flgFrameReady = 0, cntDropped = 0, peakBin = 0, peakVal = 0.
  - RAM contents are undefined after reset. The display reads undefined data until the first swap.
- Reset asserted mid-fill returns the FSM to stWaitSof and keeps the current display bank selection at its reset value (bankWr = 0).

## Timing
- A sample is written on the same edge it is accepted. There is no backpressure; the block always accepts.
- byteDisplay has 1-cycle latency from addrDisplay.
- On the swap edge bankWr toggles. A read address presented in the cycle after the swap returns data from the new display bank.
- flgFrameReady is high for exactly the cycle following the swap edge.
- peakBin and peakVal update on the swap edge and are stable for the whole display frame.

## Configuration
- FREQ_STATS_EN defined:
  - A running max is tracked during stFill over bins 1..511 (DC excluded).
  - The comparison is strict greater-than, so the lowest bin wins ties.
  - The running max is cleared on each accepted SOF.
  - The running max is latched to peakBin/peakVal at each swap.
- FREQ_STATS_EN undefined: no tracker logic is compiled in, and peakBin/peakVal are tied to 0.

## Structure
- Package freq_buf_pkg holds:
  - NUM_BINS = 512 and the writer state encoding (one-hot, 3 bits).
  - BIN_ADDR_W/DATA_W defaults.
- Sub-module freq_bank_ram: simple dual-port RAM, 1024×8, address = {bank, bin}.
  - Write port: synchronous.
  - Read port: registered. Its output register is byteDisplay.

## Test plan
- Full frame, then vsync:
  - Stimulus: stream bins 0..1023 with value = bin[7:0], then pulse vsync.
  - Required: flgFrameReady pulses once; reading addr 5 returns 5 and addr 300 returns 44. Bins ≥512 leave no trace.
- Overrun:
  - Stimulus: complete a frame, then send 3 more SOFs with no vsync, then pulse vsync.
  - Required: cntDropped = 3; the displayed data is the first frame.
- Simultaneous vsync and SOF in stFull:
  - Required: the swap occurs, bin 0 lands in the new fill bank, the state is stFill and cntDropped is unchanged.
- Out-of-order address:
  - Stimulus: during fill, jump from bin 100 to bin 200, then vsync.
  - Required: no swap and no flgFrameReady; the next clean frame is captured normally.
- Reset mid-fill:
  - Stimulus: deassert aresetn at bin 250.
  - Required: all outputs read 0 immediately (asynchronous) and the FSM is in stWaitSof. A subsequent full frame plus vsync swaps correctly.
- FREQ_STATS_EN:
  - Stimulus: bin 0 = 255, bins 40 and 77 = 200, all other bins 10, then vsync.
  - Required: peakBin = 40, peakVal = 200.
